// File: rtl/axis_pkt_capture.sv
// AXI4-Stream packet sink: stores each packet in a circular frame RAM as one header
// frame followed by its data frames, then publishes a committed write pointer.
module axis_pkt_capture #(
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned KEEP_W         = 8,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned MAX_PKT_FRAMES = 256
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              s_axis_rx_tvalid_i,
    input  logic [DATA_W-1:0] s_axis_rx_tdata_i,
    input  logic [KEEP_W-1:0] s_axis_rx_tkeep_i,
    input  logic              s_axis_rx_tlast_i,
    output logic              s_axis_rx_tready_o,
    input  logic [ADDR_W-1:0] rd_ptr_i,
    output logic              ram_en_o,
    output logic [KEEP_W-1:0] ram_wren_o,
    output logic [ADDR_W-1:0] ram_wraddr_o,
    output logic [DATA_W-1:0] ram_wrdata_o,
    output logic [ADDR_W-1:0] wr_ptr_o,
    output logic [31:0]       pkt_cnt_o,
    output logic              drop_o
);

    localparam int unsigned CNT_W  = $clog2(MAX_PKT_FRAMES + 1);
    localparam int unsigned BYTE_W = 16;

    typedef enum logic [2:0] {IDLE, DATA, HDR, COMMIT, DROP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BYTE_W-1:0]   bytes_q, bytes_d;
    logic                ram_en_d;
    logic [KEEP_W-1:0]   ram_wren_d;
    logic [ADDR_W-1:0]   ram_wraddr_d;
    logic [DATA_W-1:0]   ram_wrdata_d;
    logic [ADDR_W-1:0]   wr_ptr_d;
    logic [31:0]         pkt_cnt_d;
    logic                drop_d;
    logic [ADDR_W-1:0]   free_c;
    logic                room_c;
    logic                accept_c;
    logic [DATA_W-1:0]   hdr_c;

    function automatic logic [BYTE_W-1:0] popcount(input logic [KEEP_W-1:0] k);
        logic [BYTE_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < KEEP_W; i++) begin
            n = n + BYTE_W'(k[i]);
        end
        return n;
    endfunction

    // One slot is always kept empty so rd_ptr == wr_ptr unambiguously means empty.
    assign free_c = rd_ptr_i - wr_ptr_o - ADDR_W'(1);
    assign room_c = 32'(free_c) >= 32'(MAX_PKT_FRAMES);

    assign s_axis_rx_tready_o = resetn &
                                ((state_q == DATA) || (state_q == DROP) ||
                                 ((state_q == IDLE) && room_c));
    assign accept_c = s_axis_rx_tvalid_i & s_axis_rx_tready_o;

    always_comb begin
        hdr_c        = '0;
        hdr_c[15:0]  = 16'(cnt_q) + 16'd1;
        hdr_c[31:16] = bytes_q;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bytes_d      = bytes_q;
        ram_en_d     = 1'b0;
        ram_wren_d   = ram_wren_o;
        ram_wraddr_d = ram_wraddr_o;
        ram_wrdata_d = ram_wrdata_o;
        wr_ptr_d     = wr_ptr_o;
        pkt_cnt_d    = pkt_cnt_o;
        drop_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    ram_en_d     = 1'b1;
                    ram_wren_d   = s_axis_rx_tkeep_i;
                    ram_wraddr_d = wr_ptr_o + ADDR_W'(1);
                    ram_wrdata_d = s_axis_rx_tdata_i;
                    cnt_d        = CNT_W'(1);
                    bytes_d      = popcount(s_axis_rx_tkeep_i);
                    state_d      = s_axis_rx_tlast_i ? HDR : DATA;
                end
            end
            DATA: begin
                if (accept_c) begin
                    if (cnt_q == CNT_W'(MAX_PKT_FRAMES - 1)) begin
                        // No room left for this beat inside the packet budget.
                        if (s_axis_rx_tlast_i) begin
                            drop_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        ram_en_d     = 1'b1;
                        ram_wren_d   = s_axis_rx_tkeep_i;
                        ram_wraddr_d = wr_ptr_o + ADDR_W'(1) + ADDR_W'(cnt_q);
                        ram_wrdata_d = s_axis_rx_tdata_i;
                        cnt_d        = cnt_q + CNT_W'(1);
                        bytes_d      = bytes_q + popcount(s_axis_rx_tkeep_i);
                        state_d      = s_axis_rx_tlast_i ? HDR : DATA;
                    end
                end
            end
            HDR: begin
                ram_en_d     = 1'b1;
                ram_wren_d   = '1;
                ram_wraddr_d = wr_ptr_o;
                ram_wrdata_d = hdr_c;
                state_d      = COMMIT;
            end
            COMMIT: begin
                wr_ptr_d  = wr_ptr_o + ADDR_W'(cnt_q) + ADDR_W'(1);
                pkt_cnt_d = pkt_cnt_o + 32'd1;
                state_d   = IDLE;
            end
            DROP: begin
                if (accept_c && s_axis_rx_tlast_i) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bytes_q      <= '0;
            ram_en_o     <= 1'b0;
            ram_wren_o   <= '0;
            ram_wraddr_o <= '0;
            ram_wrdata_o <= '0;
            wr_ptr_o     <= '0;
            pkt_cnt_o    <= '0;
            drop_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bytes_q      <= bytes_d;
            ram_en_o     <= ram_en_d;
            ram_wren_o   <= ram_wren_d;
            ram_wraddr_o <= ram_wraddr_d;
            ram_wrdata_o <= ram_wrdata_d;
            wr_ptr_o     <= wr_ptr_d;
            pkt_cnt_o    <= pkt_cnt_d;
            drop_o       <= drop_d;
        end
    end

endmodule

// File: tb/tb_axis_pkt_capture.sv
// Self-checking bench for axis_pkt_capture: table-driven vectors, corner-case sequences
// and random packets compared against a packet-level model of the ring layout.
module tb_axis_pkt_capture;

    localparam int MAX_FRAMES = 256;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [9:0]  addr;
        logic [7:0]  wren;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        int          nbeats;
        logic [7:0]  last_keep;
        logic [9:0]  exp_wr;
        logic [63:0] exp_hdr;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        tvalid;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tready;
    logic [9:0]  rd_ptr;
    logic        ram_en;
    logic [7:0]  ram_wren;
    logic [9:0]  ram_wraddr;
    logic [63:0] ram_wrdata;
    logic [9:0]  wr_ptr;
    logic [31:0] pkt_cnt;
    logic        drop;

    int          checks = 0;
    int          errors = 0;
    int          drops_seen = 0;
    int          hi;
    beat_t       tx_q[$];
    wr_t         exp_q[$];
    wr_t         log_q[$];
    wr_t         mon_w;
    logic [9:0]  mdl_wp;
    int          mdl_pkts;
    vec_t        vecs[5];
    logic [2:0]  gap;
    logic [49:0] wa;

    always #5 clk = ~clk;

    axis_pkt_capture #(
        .DATA_W(64), .KEEP_W(8), .ADDR_W(10), .MAX_PKT_FRAMES(MAX_FRAMES)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s_axis_rx_tvalid_i(tvalid), .s_axis_rx_tdata_i(tdata),
        .s_axis_rx_tkeep_i(tkeep), .s_axis_rx_tlast_i(tlast),
        .s_axis_rx_tready_o(tready), .rd_ptr_i(rd_ptr),
        .ram_en_o(ram_en), .ram_wren_o(ram_wren), .ram_wraddr_o(ram_wraddr),
        .ram_wrdata_o(ram_wrdata), .wr_ptr_o(wr_ptr), .pkt_cnt_o(pkt_cnt), .drop_o(drop)
    );

    // RAM write and drop monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (resetn === 1'b1 && ram_en === 1'b1) begin
            mon_w.addr = ram_wraddr;
            mon_w.wren = ram_wren;
            mon_w.data = ram_wrdata;
            log_q.push_back(mon_w);
        end
        if (resetn === 1'b1 && drop === 1'b1) drops_seen++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] keep_of(input int k);
        int v;
        v = (1 << k) - 1;
        return 8'(v);
    endfunction

    // Packet-level model: data beats land after the header slot, header at the old pointer.
    task automatic add_pkt(input int n, input bit rnd_keep, input logic [7:0] last_keep);
        beat_t b;
        wr_t   w;
        int    bytes;
        bytes = 0;
        for (int i = 0; i < n; i++) begin
            b.data = {$urandom, $urandom};
            b.last = (i == n - 1);
            if (rnd_keep) b.keep = keep_of(int'($urandom_range(0, 8)));
            else          b.keep = b.last ? last_keep : 8'hFF;
            tx_q.push_back(b);
            if (i < MAX_FRAMES - 1) begin
                w.addr = 10'(int'(mdl_wp) + 1 + i);
                w.wren = b.keep;
                w.data = b.data;
                exp_q.push_back(w);
                bytes += $countones(b.keep);
            end
        end
        if (n <= MAX_FRAMES - 1) begin
            w.addr = mdl_wp;
            w.wren = 8'hFF;
            w.data = {32'h0, 16'(bytes), 16'(n + 1)};
            exp_q.push_back(w);
            mdl_wp = 10'(int'(mdl_wp) + n + 1);
            mdl_pkts++;
        end
    endtask

    task automatic drive_all();
        int   budget;
        logic acc;
        budget = tx_q.size() * 4 + 64;
        while (tx_q.size() > 0) begin
            tvalid = 1'b1;
            tdata  = tx_q[0].data;
            tkeep  = tx_q[0].keep;
            tlast  = tx_q[0].last;
            @(negedge clk);
            acc = tready;
            @(posedge clk);
            #1;
            if (acc) void'(tx_q.pop_front());
            budget--;
            if (budget == 0 && tx_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drive_timeout: %0d beats left, expected 0", tx_q.size());
                tx_q.delete();
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compare_log(input string name);
        int idx;
        idx = -1;
        checks++;
        if (log_q.size() == exp_q.size()) begin
            for (int i = 0; i < log_q.size(); i++) begin
                if (log_q[i] !== exp_q[i]) begin
                    idx = i;
                    break;
                end
            end
        end else begin
            idx = 0;
        end
        if (idx >= 0) begin
            errors++;
            if (log_q.size() != exp_q.size())
                $display("FAIL %s: %0d writes, expected %0d", name, log_q.size(), exp_q.size());
            else
                $display("FAIL %s: write %0d got %h expected %h", name, idx, log_q[idx], exp_q[idx]);
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_model();
        mdl_wp   = '0;
        mdl_pkts = 0;
        log_q.delete();
        exp_q.delete();
        tx_q.delete();
        drops_seen = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tvalid = 1'b0;
        tlast  = 1'b0;
        rd_ptr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        clear_model();
    endtask

    function automatic logic [63:0] last_hdr();
        if (log_q.size() == 0) return 64'hx;
        return log_q[log_q.size() - 1].data;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3,   8'h0F, 10'd4,   64'h0000_0000_0014_0004};
        vecs[1] = '{1,   8'hFF, 10'd6,   64'h0000_0000_0008_0002};
        vecs[2] = '{2,   8'h00, 10'd9,   64'h0000_0000_0008_0003};
        vecs[3] = '{5,   8'h01, 10'd15,  64'h0000_0000_0021_0006};
        vecs[4] = '{255, 8'hFF, 10'd271, 64'h0000_0000_07F8_0100};

        resetn = 1'b0; tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; rd_ptr = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ram_ctl", {ram_en, ram_wren, ram_wraddr}, 0);
        check("rst_ram_data", ram_wrdata, 0);
        check("rst_wr_ptr", wr_ptr, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_drop_tready", {drop, tready}, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("idle_tready", tready, 1);

        // Table vectors, each into an empty ring.
        for (int i = 0; i < 5; i++) begin
            rd_ptr = mdl_wp;
            add_pkt(vecs[i].nbeats, 1'b0, vecs[i].last_keep);
            drive_all();
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                gap[2 - c] = tready;
            end
            settle();
            check($sformatf("vec%0d_gap", i), 64'(gap), 64'(3'b001));
            check($sformatf("vec%0d_wr_ptr", i), 64'(wr_ptr), 64'(vecs[i].exp_wr));
            check($sformatf("vec%0d_pkt_cnt", i), 64'(pkt_cnt), 64'(i + 1));
            check($sformatf("vec%0d_hdr", i), last_hdr(), vecs[i].exp_hdr);
            compare_log($sformatf("vec%0d_log", i));
        end

        // Back-to-back random packets with tvalid held high.
        rd_ptr = mdl_wp;
        drops_seen = 0;
        for (int p = 0; p < 10; p++) add_pkt(int'($urandom_range(1, 20)), 1'b1, 8'h00);
        drive_all();
        settle();
        check("b2b_pkt_cnt", 64'(pkt_cnt), 64'(mdl_pkts));
        check("b2b_pkt_cnt_abs", 64'(pkt_cnt), 64'd15);
        check("b2b_drops", 64'(drops_seen), 0);
        check("b2b_wr_ptr", 64'(wr_ptr), 64'(mdl_wp));
        compare_log("b2b_log");

        // Backpressure: 199 free frames holds tready low in IDLE.
        do_reset();
        rd_ptr = 10'd200;
        tvalid = 1'b1; tdata = {$urandom, $urandom}; tkeep = 8'hFF; tlast = 1'b1;
        hi = 0;
        repeat (8) begin
            @(negedge clk);
            if (tready) hi++;
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        check("bp_tready_high", 64'(hi), 0);
        check("bp_no_writes", 64'(log_q.size()), 0);
        rd_ptr = 10'd300;
        add_pkt(1, 1'b0, 8'hFF);
        drive_all();
        settle();
        check("bp_wr_ptr", 64'(wr_ptr), 64'd2);
        check("bp_hdr", last_hdr(), 64'h0000_0000_0008_0002);
        compare_log("bp_log");

        // Fill to 1022 with maximum-size packets, then straddle the wrap point.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            rd_ptr = mdl_wp;
            add_pkt((p == 3) ? 253 : 255, 1'b1, 8'h00);
            drive_all();
            settle();
        end
        check("fill_wr_ptr", 64'(wr_ptr), 64'd1022);
        compare_log("fill_log");
        rd_ptr = 10'd1022;
        add_pkt(4, 1'b0, 8'h07);
        drive_all();
        settle();
        if (log_q.size() == 5)
            wa = {log_q[0].addr, log_q[1].addr, log_q[2].addr, log_q[3].addr, log_q[4].addr};
        else
            wa = '1;
        check("wrap_addrs", 64'(wa), 64'({10'd1023, 10'd0, 10'd1, 10'd2, 10'd1022}));
        check("wrap_wr_ptr", 64'(wr_ptr), 64'd3);
        check("wrap_pkt_cnt", 64'(pkt_cnt), 64'd5);
        compare_log("wrap_log");

        // Oversize packet is dropped, then a normal packet reuses the same slot.
        rd_ptr = mdl_wp;
        drops_seen = 0;
        add_pkt(300, 1'b0, 8'hFF);
        drive_all();
        settle();
        check("ovs_drops", 64'(drops_seen), 64'd1);
        check("ovs_wr_ptr", 64'(wr_ptr), 64'd3);
        check("ovs_pkt_cnt", 64'(pkt_cnt), 64'd5);
        check("ovs_writes", 64'(log_q.size()), 64'd255);
        compare_log("ovs_log");
        add_pkt(2, 1'b0, 8'h3F);
        drive_all();
        settle();
        check("post_ovs_wr_ptr", 64'(wr_ptr), 64'd6);
        check("post_ovs_hdr", last_hdr(), 64'h0000_0000_000E_0003);
        check("post_ovs_pkt_cnt", 64'(pkt_cnt), 64'd6);
        compare_log("post_ovs_log");

        // Reset in the middle of a packet.
        rd_ptr = mdl_wp;
        for (int b = 0; b < 2; b++) begin
            tvalid = 1'b1; tdata = {$urandom, $urandom}; tkeep = 8'hFF; tlast = 1'b0;
            @(posedge clk);
            #1;
        end
        resetn = 1'b0;
        tvalid = 1'b0;
        #1;
        check("mid_rst_ram_ctl", {ram_en, ram_wren, ram_wraddr}, 0);
        check("mid_rst_ram_data", ram_wrdata, 0);
        check("mid_rst_ptrs", {wr_ptr, pkt_cnt}, 0);
        check("mid_rst_drop_tready", {drop, tready}, 0);
        rd_ptr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        clear_model();
        add_pkt(1, 1'b0, 8'hFF);
        drive_all();
        settle();
        check("mid_rst_hdr", last_hdr(), 64'h0000_0000_0008_0002);
        check("mid_rst_wr_ptr", 64'(wr_ptr), 64'd2);
        check("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd1);
        compare_log("mid_rst_log");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_pkt_capture.md
Name: axis_pkt_capture

Overview:
- AXI4-Stream sink that captures packets leaving the packet processor's parser TX port into a circular frame RAM, one DATA_W-bit frame per beat.
- Uses the same layout the packet loader produces: one header frame followed by the data frames.
- Publishes a committed write pointer. A software/bench reader drains the RAM and returns its read pointer.
- It is the write-side counterpart of axis_convertor: stream in, RAM out.

Parameters:
- DATA_W, 64, stream data width and RAM frame width.
- KEEP_W, 8, tkeep width (DATA_W/8).
- ADDR_W, 10, frame RAM address width; ring size 2^ADDR_W frames.
- MAX_PKT_FRAMES, 256, maximum frames per packet including the header.

Ports:
- clk, in, 1, clock.
- resetn, in, 1, reset, asynchronous, active-low.
- s_axis_rx_tvalid_i, in, 1, stream valid.
- s_axis_rx_tdata_i, in, DATA_W, stream data.
- s_axis_rx_tkeep_i, in, KEEP_W, byte enables, contiguous from LSB.
- s_axis_rx_tlast_i, in, 1, last beat of packet.
- s_axis_rx_tready_o, out, 1, stream ready.
- rd_ptr_i, in, ADDR_W, consumer read pointer (first unread frame).
- ram_en_o, out, 1, RAM write strobe.
- ram_wren_o, out, KEEP_W, byte write enables.
- ram_wraddr_o, out, ADDR_W, write address.
- ram_wrdata_o, out, DATA_W, write data.
- wr_ptr_o, out, ADDR_W, committed write pointer (next packet's header slot).
- pkt_cnt_o, out, 32, committed packet count.
- drop_o, out, 1, one-cycle pulse per dropped packet.

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0. Reset mid-packet discards the partial packet; wr_ptr_o returns to 0. The consumer must also reset rd_ptr_i.
- Free space: free = (rd_ptr_i - wr_ptr_o - 1) mod 2^ADDR_W. rd_ptr_i == wr_ptr_o means empty, so at most 2^ADDR_W-1 frames are held.
- A beat is accepted when tvalid & tready at a rising edge.
- States:
  - IDLE: tready = (free >= MAX_PKT_FRAMES). On acceptance: write beat to wr_ptr_o+1, frame count = 1, byte count = popcount(tkeep). If tlast, go HDR; else go DATA.
  - DATA: tready = 1. Each accepted beat writes to wr_ptr_o+1+count (mod 2^ADDR_W) and increments both counters.
    - tlast goes to HDR.
    - A non-last or last beat accepted when count == MAX_PKT_FRAMES-1 is not written and goes to DROP. If that beat carries tlast, go to IDLE instead and pulse drop_o.
  - HDR: tready = 0. Write header to wr_ptr_o with wren all-ones, then go COMMIT.
  - COMMIT: tready = 0. wr_ptr_o <= wr_ptr_o + count + 1 (mod 2^ADDR_W); pkt_cnt_o++; go IDLE.
  - DROP: tready = 1; no RAM writes. On accepted tlast, pulse drop_o and go IDLE. wr_ptr_o and pkt_cnt_o are unchanged.
- Header frame:
  - [15:0] = total frames including the header.
  - [31:16] = byte count (sum of popcount(tkeep)).
  - [DATA_W-1:32] = 0.
- RAM outputs are registered:
  - A beat accepted at edge k appears on ram_* after edge k.
  - ram_en_o is high for exactly one cycle per write.
  - Data writes use ram_wren_o = tkeep. Header writes use all-ones.
- The header write is presented one cycle before wr_ptr_o advances, so the reader never sees an uncommitted packet.
- Throughput: one beat per cycle within a packet. tready is low for 2 cycles after each committed tlast (HDR, COMMIT).
- All address arithmetic wraps modulo 2^ADDR_W. A packet may straddle the wrap point.
- rd_ptr_i is sampled only in IDLE. Changes during a packet do not affect acceptance of that packet.
- tkeep == 0 on a beat is written as-is and counts 0 bytes.

Test Plan:
- Basic packet: ADDR_W=10, empty ring; 3 beats, last tkeep=0x0F -> data written at 1,2,3; header 0x0000_0000_0014_0004 written at 0; wr_ptr_o=4; pkt_cnt_o=1; tready low exactly 2 cycles after tlast.
- Backpressure: wr_ptr_o=0, rd_ptr_i=200 (free=199) -> tready stays 0 in IDLE. Set rd_ptr_i=300 (free=299) -> next packet accepted.
- Wrap: wr_ptr_o=1022, rd_ptr_i=1022; 4-beat packet -> header at 1022, data at 1023,0,1,2; wr_ptr_o=3.
- Oversize: 300-beat packet -> beats 1..255 accepted and written, the rest consumed with no writes; drop_o pulses once on tlast; wr_ptr_o and pkt_cnt_o unchanged. The following 2-beat packet commits normally with its header at the old wr_ptr_o.
- Reset mid-packet: assert resetn=0 after beat 2 of 5 -> all outputs 0 immediately. After release, a fresh 1-beat packet (tkeep=0xFF) -> header 0x0000_0000_0008_0002 at 0; wr_ptr_o=2.
- Back-to-back: 10 packets of random 1..20 beats with tvalid held high -> headers and data match the model; pkt_cnt_o=10; no drop_o pulses.
